// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: word type, FSM states, Rcon and S-box tables.
// Pure declarations and constant functions; no logic, latency or flow control of its own.
package aes_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  // Indexed by i/NK; entry 0 is never used, the tail pads the 4-bit index.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
// Purely combinational, zero latency, no flow control.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = {SBOX[din[31:24]], SBOX[din[23:16]], SBOX[din[15:8]], SBOX[din[7:0]]};

endmodule

// File: rtl/aes_key_streamer.sv
// AES key expansion (one word/cycle, NW-NK cycles) then round keys Nr..0 over valid/ready;
// AES_EQINV_KEY_EN outputs InvMixColumns of middle rounds; a stalled key holds until accepted.
module aes_key_streamer
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [0:32*NK-1]  Key,
  output logic              busy,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [0:127]      rk_data,
  output logic [3:0]        rk_round,
  output logic              done
);

  localparam int         NR      = nr_of(NK);
  localparam int         NW      = 4 * (NR + 1);
  localparam logic [5:0] NK_W    = 6'(NK);
  localparam logic [5:0] NW_LAST = 6'(NW - 1);
  localparam logic [2:0] NK_M1   = 3'(NK - 1);
  localparam logic [3:0] NR_W    = 4'(NR);

  state_e      state;
  logic [5:0]  i;
  logic [2:0]  pos;     // i mod NK, tracked incrementally to avoid a divider
  logic [3:0]  rc_idx;  // i / NK
  word_t       w [0:NW-1];
  word_t       prev;
  word_t       older;
  word_t       sub_in;
  word_t       sub_out;
  word_t       temp;
  word_t       c0, c1, c2, c3;
  logic [127:0] raw_key;
  logic [127:0] out_key;

  assign prev   = w[i - 6'd1];
  assign older  = w[i - NK_W];
  assign sub_in = (pos == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  aes_sbox_word u_sbox (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    temp = prev;
    if (pos == 3'd0) begin
      temp = sub_out ^ {RCON[rc_idx], 24'h000000};
    end else if (NK == 8 && pos == 3'd4) begin
      temp = sub_out;
    end
  end

  // Word storage is deliberately not reset; rk_valid gating hides stale contents.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      for (int k = 0; k < NK; k++) begin
        w[k] <= Key[32*k +: 32];
      end
    end else if (state == ST_EXPAND) begin
      w[i] <= older ^ temp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      i        <= '0;
      pos      <= '0;
      rc_idx   <= '0;
      rk_round <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_EXPAND;
            i      <= NK_W;
            pos    <= '0;
            rc_idx <= 4'd1;
          end
        end
        ST_EXPAND: begin
          i <= i + 6'd1;
          if (pos == NK_M1) begin
            pos    <= '0;
            rc_idx <= rc_idx + 4'd1;
          end else begin
            pos <= pos + 3'd1;
          end
          if (i == NW_LAST) begin
            state    <= ST_STREAM;
            rk_round <= NR_W;
          end
        end
        ST_STREAM: begin
          if (rk_ready) begin
            if (rk_round == 4'd0) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              rk_round <= rk_round - 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign rk_valid = (state == ST_STREAM);

  assign c0      = w[{rk_round, 2'd0}];
  assign c1      = w[{rk_round, 2'd1}];
  assign c2      = w[{rk_round, 2'd2}];
  assign c3      = w[{rk_round, 2'd3}];
  assign raw_key = {c0, c1, c2, c3};

`ifdef AES_EQINV_KEY_EN
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a constant made of the bits 1,2,4,8 (covers 09, 0b, 0d, 0e).
  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic word_t inv_mix(input word_t c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
            gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
            gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
            gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
  endfunction

  logic mixed;
  assign mixed   = (rk_round != 4'd0) && (rk_round != NR_W);
  assign out_key = mixed ? {inv_mix(c0), inv_mix(c1), inv_mix(c2), inv_mix(c3)} : raw_key;
`else
  assign out_key = raw_key;
`endif

  assign rk_data = rk_valid ? out_key : '0;

endmodule

// File: tb/tb_aes_key_streamer.sv
// Bench for aes_key_streamer: NK=4/6/8 instances checked every cycle against a FIPS-197 software model.
`timescale 1ns/1ps
module tb_aes_key_streamer;

  localparam logic [127:0] K4  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K6  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K8  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] L4  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] L6  = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] L8  = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         st [3];
  logic         rdy [3];
  logic         bsy [3];
  logic         vld [3];
  logic         dn [3];
  logic [127:0] dat [3];
  logic [3:0]   rnd [3];
  logic [255:0] kk [3];

  int checks = 0;
  int failures = 0;

  aes_key_streamer #(.NK(4)) u_nk4 (.clk(clk), .rst_n(rst_n), .start(st[0]), .Key(kk[0][255:128]),
    .busy(bsy[0]), .rk_valid(vld[0]), .rk_ready(rdy[0]), .rk_data(dat[0]), .rk_round(rnd[0]), .done(dn[0]));
  aes_key_streamer #(.NK(6)) u_nk6 (.clk(clk), .rst_n(rst_n), .start(st[1]), .Key(kk[1][255:64]),
    .busy(bsy[1]), .rk_valid(vld[1]), .rk_ready(rdy[1]), .rk_data(dat[1]), .rk_round(rnd[1]), .done(dn[1]));
  aes_key_streamer #(.NK(8)) u_nk8 (.clk(clk), .rst_n(rst_n), .start(st[2]), .Key(kk[2]),
    .busy(bsy[2]), .rk_valid(vld[2]), .rk_ready(rdy[2]), .rk_data(dat[2]), .rk_round(rnd[2]), .done(dn[2]));

  // ---------------- software model ----------------
  logic [7:0]   sb [256];
  logic [31:0]  ew [3][60];
  int           nk_of [3] = '{4, 6, 8};
  int           phase [3] = '{0, 0, 0};   // 0 idle, 1 expanding, 2 streaming
  int           left [3];
  int           nxt [3];
  bit           exp_done [3] = '{0, 0, 0};
  int           exp_cnt [3] = '{0, 0, 0};
  int           done_cnt [3] = '{0, 0, 0};
  logic [127:0] got [3][16];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (v != 0 && gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] rcon(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int n = 1; n < j; n++) r = gmul(r, 8'h02);
    return r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [31:0] invmix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  task automatic expand_model(input int m, input logic [255:0] k);
    int nk, nw;
    logic [31:0] t;
    nk = nk_of[m];
    nw = 4 * (nk + 7);
    for (int n = 0; n < nk; n++) ew[m][n] = k[255 - 32*n -: 32];
    for (int n = nk; n < nw; n++) begin
      t = ew[m][n-1];
      if (n % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon(n / nk), 24'h000000};
      else if (nk > 6 && n % nk == 4) t = subw(t);
      ew[m][n] = ew[m][n-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int m, input int r);
    logic [127:0] v;
    v = {ew[m][4*r], ew[m][4*r+1], ew[m][4*r+2], ew[m][4*r+3]};
`ifdef AES_EQINV_KEY_EN
    if (r != 0 && r != nk_of[m] + 6)
      for (int c = 0; c < 4; c++) v[127 - 32*c -: 32] = invmix(v[127 - 32*c -: 32]);
`endif
    return v;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int m = 0; m < 3; m++) begin
      if (!rst_n) begin
        chk($sformatf("reset outputs nk%0d", nk_of[m]), {bsy[m], vld[m], dn[m], rnd[m], dat[m]}, '0);
        phase[m] = 0;
        exp_done[m] = 0;
      end else begin
        chk($sformatf("busy nk%0d", nk_of[m]), bsy[m], phase[m] != 0);
        chk($sformatf("rk_valid nk%0d", nk_of[m]), vld[m], phase[m] == 2);
        chk($sformatf("done nk%0d", nk_of[m]), dn[m], exp_done[m]);
        exp_done[m] = 0;
        if (phase[m] == 2) begin
          chk($sformatf("rk_round nk%0d", nk_of[m]), rnd[m], nxt[m]);
          chk($sformatf("rk_data nk%0d r%0d", nk_of[m], nxt[m]), dat[m], exp_rk(m, nxt[m]));
          got[m][rnd[m]] = dat[m];
        end else begin
          chk($sformatf("rk_data zero nk%0d", nk_of[m]), dat[m], '0);
        end
        if (bsy[m] && !vld[m]) exp_cnt[m]++;
        if (dn[m]) done_cnt[m]++;
        case (phase[m])
          0: if (st[m]) begin
               expand_model(m, kk[m]);
               phase[m] = 1;
               left[m] = 4 * (nk_of[m] + 7) - nk_of[m];
             end
          1: begin
               left[m]--;
               if (left[m] == 0) begin
                 phase[m] = 2;
                 nxt[m] = nk_of[m] + 6;
               end
             end
          default: if (rdy[m]) begin
               if (nxt[m] == 0) begin
                 phase[m] = 0;
                 exp_done[m] = 1;
               end else begin
                 nxt[m]--;
               end
             end
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input int m);
    @(posedge clk); #1 st[m] = 1'b1;
    @(posedge clk); #1 st[m] = 1'b0;
  endtask

  task automatic run_ref4(input string tag);
    kk[0] = {K4, 128'h0};
    rdy[0] = 1'b1;
    exp_cnt[0] = 0;
    done_cnt[0] = 0;
    got[0][10] = '0;
    got[0][0] = '0;
    pulse_start(0);
    for (int c = 0; c < 200 && done_cnt[0] == 0; c++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " expand cycles"}, exp_cnt[0], 40);
    chk({tag, " round10"}, got[0][10], L4);
    chk({tag, " round0"}, got[0][0], K4);
    chk({tag, " done pulses"}, done_cnt[0], 1);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    for (int m = 0; m < 3; m++) begin
      st[m] = 1'b0;
      rdy[m] = 1'b0;
      kk[m] = '0;
    end
    build_sbox();

    chk("model sbox 00", sb[8'h00], 8'h63);
    chk("model sbox 53", sb[8'h53], 8'hed);
    chk("model invmix", invmix(32'h8e4da1bc), 32'hdb135345);
    expand_model(0, {K4, 128'h0});
    chk("model nk4 r10", exp_rk(0, 10), L4);
    chk("model nk4 r0", exp_rk(0, 0), K4);
    expand_model(1, {K6, 64'h0});
    chk("model nk6 r12", exp_rk(1, 12), L6);
    expand_model(2, K8);
    chk("model nk8 r14", exp_rk(2, 14), L8);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // All three key sizes with the consumer always ready.
    kk[0] = {K4, 128'h0};
    kk[1] = {K6, 64'h0};
    kk[2] = K8;
    for (int m = 0; m < 3; m++) begin
      rdy[m] = 1'b1;
      exp_cnt[m] = 0;
      done_cnt[m] = 0;
    end
    @(posedge clk); #1 st[0] = 1'b1; st[1] = 1'b1; st[2] = 1'b1;
    @(posedge clk); #1 st[0] = 1'b0; st[1] = 1'b0; st[2] = 1'b0;
    for (int c = 0; c < 200 && (done_cnt[0] == 0 || done_cnt[1] == 0 || done_cnt[2] == 0); c++) begin
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("nk4 expand cycles", exp_cnt[0], 40);
    chk("nk6 expand cycles", exp_cnt[1], 46);
    chk("nk8 expand cycles", exp_cnt[2], 52);
    chk("nk4 first key", got[0][10], L4);
    chk("nk4 last key", got[0][0], K4);
    chk("nk6 round12", got[1][12], L6);
    chk("nk8 round14", got[2][14], L8);
    for (int m = 0; m < 3; m++) chk($sformatf("nk%0d done pulses", nk_of[m]), done_cnt[m], 1);

    // Random back-pressure, spurious starts while busy and Key churn after capture.
    for (int it = 0; it < 3; it++) begin
      kk[0] = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      done_cnt[0] = 0;
      pulse_start(0);
      for (int c = 0; c < 1500 && done_cnt[0] == 0; c++) begin
        rdy[0] = 1'($urandom_range(0, 1));
        st[0] = bsy[0] && ($urandom_range(0, 7) == 0);
        kk[0][255:128] = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
      end
      st[0] = 1'b0;
      rdy[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk($sformatf("stall run %0d done pulses", it), done_cnt[0], 1);
    end

    // start coincident with the round-0 handshake must be dropped.
    kk[0] = {K4, 128'h0};
    rdy[0] = 1'b1;
    pulse_start(0);
    found = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (vld[0] && rnd[0] == 4'd0) begin
        found = 1;
        break;
      end
    end
    chk("round0 reached", found, 1);
    st[0] = 1'b1;
    @(posedge clk); #1 st[0] = 1'b0;
    chk("collision done/idle", {bsy[0], dn[0]}, 2'b01);
    repeat (3) @(posedge clk);
    #1 chk("collision no restart", bsy[0], 0);

    // Reset mid-EXPAND.
    kk[0] = {K4, 128'h0};
    pulse_start(0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("reset in expand", {bsy[0], vld[0], dn[0], rnd[0], dat[0]}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_ref4("after expand reset");

    // Reset mid-STREAM.
    kk[0] = {K4, 128'h0};
    pulse_start(0);
    found = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (vld[0] && rnd[0] == 4'd5) begin
        found = 1;
        break;
      end
    end
    chk("round5 reached", found, 1);
    rst_n = 1'b0;
    #1 chk("reset in stream", {bsy[0], vld[0], dn[0], rnd[0], dat[0]}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_ref4("after stream reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_streamer.md
AES_KEY_STREAMER -- requirements
Module: aes_key_streamer

Interface
REQ-001 The block SHALL have parameter NK, default 4, giving the cipher key length in 32-bit words; legal values are 4, 6 and 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle request to load Key and begin.
REQ-005 The block SHALL have port Key, input, [0:32*NK-1]: the cipher key, with bit 0 as the MSB of word 0.
REQ-006 The block SHALL have port busy, output, 1 bit: high whenever the block is not in IDLE.
REQ-007 The block SHALL have port rk_valid, output, 1 bit: rk_data and rk_round are valid.
REQ-008 The block SHALL have port rk_ready, input, 1 bit: the consumer accepts the current round key.
REQ-009 The block SHALL have port rk_data, output, [0:127]: the round key, formed from words w[4r]..w[4r+3], with w[4r] in bits 0..31.
REQ-010 The block SHALL have port rk_round, output, 4 bits: the round index r of rk_data.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse after round 0 is accepted.

Function
REQ-012 The block SHALL derive Nr = NK+6 and a word count NW = 4*(Nr+1), giving 44, 52 or 60.
REQ-013 The state machine SHALL have three states: IDLE, EXPAND and STREAM.
- IDLE -> EXPAND on start.
- EXPAND -> STREAM after w[NW-1] is written.
- STREAM -> IDLE on the handshake for round 0.
REQ-014 On start in IDLE, the block SHALL capture Key into w[0..NK-1] and set the word index i to NK.
REQ-015 In EXPAND, the block SHALL compute exactly one word per cycle, w[i] = w[i-NK] xor temp, where temp is:
- SubWord(RotWord(w[i-1])) xor Rcon[i/NK] when i mod NK = 0;
- SubWord(w[i-1]) when NK = 8 and i mod 8 = 4;
- w[i-1] otherwise.
REQ-016 EXPAND SHALL last NW-NK cycles (40, 46 or 52); rk_valid SHALL rise on the following cycle.
REQ-017 STREAM SHALL present round keys in descending order, r = Nr down to 0, with rk_round = r.
REQ-018 Once rk_valid is high, rk_data and rk_round SHALL hold stable until rk_valid and rk_ready are both high on a rising edge.
REQ-019 A handshake SHALL advance r on the next cycle; back-to-back acceptance SHALL give one round key per cycle.
REQ-020 done SHALL pulse in the cycle after the round-0 handshake, coincident with return to IDLE, busy low and rk_valid low.
REQ-021 start SHALL be ignored while busy is high.
REQ-022 Key SHALL be sampled only in the start cycle; later Key changes SHALL have no effect.
REQ-023 If start and a round-0 handshake occur in the same cycle, the start SHALL be ignored.
REQ-024 rk_data SHALL be all-zero whenever rk_valid is low.

Reset
REQ-025 While rst_n is low, the block SHALL force the following, independent of clk:
- state = IDLE;
- busy, rk_valid and done = 0;
- rk_data = 0 and rk_round = 0;
- i = 0.
REQ-026 Reset during EXPAND or STREAM SHALL abandon the operation; word storage need not be cleared, and no stale round key SHALL be presented afterwards.

Configuration
REQ-027 With AES_EQINV_KEY_EN defined, rounds 1..Nr-1 SHALL be output as InvMixColumns(round key), for the equivalent inverse cipher.
- Rounds Nr and 0 SHALL be output unmodified.
- The transform SHALL be combinational on the output path and SHALL add no latency.
REQ-028 Without AES_EQINV_KEY_EN, all round keys SHALL be output unmodified, and no InvMixColumns logic SHALL be present.

Structure
REQ-029 The shared package aes_pkg SHALL hold:
- the Rcon table;
- the S-box table;
- the function nr_of(NK);
- the 32-bit word typedef;
- the state enum.
REQ-030 A combinational sub-module aes_sbox_word SHALL perform SubWord (four S-box lookups); it SHALL be instantiated once.

Verification
REQ-031 With NK=4, Key=2b7e151628aed2a6abf7158809cf4f3c and rk_ready held high, the bench SHALL confirm:
- 40 cycles of busy before rk_valid;
- first rk_data = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_round = 10;
- last rk_data = the Key with rk_round = 0;
- then a single done pulse.
REQ-032 With NK=6, Key=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, the bench SHALL confirm 46 EXPAND cycles and round 12 = e98ba06f448c773c8ecc720401002202.
REQ-033 With NK=8, Key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, the bench SHALL confirm 52 EXPAND cycles and round 14 = fe4890d1e6188d0b046df344706c631e.
REQ-034 With NK=4 and rk_ready toggled pseudo-randomly, with start re-pulsed during STREAM, the bench SHALL confirm:
- rk_data is stable while stalled;
- no round is skipped or repeated;
- the extra start is ignored.
REQ-035 With rst_n asserted mid-EXPAND and again mid-STREAM, the bench SHALL confirm:
- the outputs are immediately zero and the state is IDLE;
- a fresh start then reproduces the vector from REQ-031 exactly.
REQ-036 With AES_EQINV_KEY_EN defined and NK=4, the bench SHALL confirm:
- rounds 10 and 0 match REQ-031;
- rounds 9..1 equal InvMixColumns of the FIPS-197 round keys from the software model.
